// File: rtl/arb_pkg.sv
// Shared constants and FSM state type for the 8-to-1 byte arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } state_t;

endpackage : arb_pkg

// File: rtl/mux_8to1_8b.sv
// Plain combinational 8-to-1 byte multiplexer.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows sel and inputs.
//
// Ports: sel - channel index; in0..in7 - channel bytes; out - selected byte.
module mux_8to1_8b (
  input  logic [2:0] sel,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [7:0] in4,
  input  logic [7:0] in5,
  input  logic [7:0] in6,
  input  logic [7:0] in7,
  output logic [7:0] out
);

  always_comb begin
    out = in0;
    case (sel)
      3'd0: out = in0;
      3'd1: out = in1;
      3'd2: out = in2;
      3'd3: out = in3;
      3'd4: out = in4;
      3'd5: out = in5;
      3'd6: out = in6;
      3'd7: out = in7;
      default: out = in0;
    endcase
  end

endmodule : mux_8to1_8b

// File: rtl/rr_pick8.sv
// Round-robin picker: first set req bit scanning upward from start, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports: req - request vector; start - first index to examine;
//        idx - chosen index (0 when nothing requests); any - some bit of req is set.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0] probe;

  // Walk offsets from farthest to nearest so the nearest hit overwrites the rest.
  always_comb begin
    idx   = '0;
    probe = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      probe = start + IDX_W'(k);
      if (req[probe]) idx = probe;
    end
    any = |req;
  end

endmodule : rr_pick8

// File: rtl/arb_8to1_8b.sv
// Round-robin 8-to-1 byte arbiter with bursts bounded to BURST_LEN transfers per owner.
// Latency: 1 cycle from req/grant handshake to out_valid/out_data; 1 byte/cycle throughput.
// Backpressure: out_valid & ~out_ready freezes all state and forces grant to zero.
//
// Ports: clk, rst (sync, active-high); req/in0..in7 - per-channel valid and data;
//        grant - one-hot per-channel ready; sel/out_data/out_valid/out_ready - output stream.
module arb_8to1_8b
  import arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic [DATA_W-1:0] in0,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [DATA_W-1:0] in3,
  input  logic [DATA_W-1:0] in4,
  input  logic [DATA_W-1:0] in5,
  input  logic [DATA_W-1:0] in6,
  input  logic [DATA_W-1:0] in7,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  state_t           state;
  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] last;
  logic [7:0]       cnt;

  logic             load;
  logic             cont;
  logic             any_req;
  logic             xfer;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] winner;
  logic [DATA_W-1:0] mux_dat;

  // Scan starts one past the last grant; 3-bit add wraps 7 -> 0.
  rr_pick8 u_pick (
    .req   (req),
    .start (last + IDX_W'(1)),
    .idx   (rr_idx),
    .any   (any_req)
  );

  always_comb begin
    load   = ~out_valid | out_ready;
    cont   = (state == OWNED) && req[cur] && (cnt < BURST_MAX);
    winner = cont ? cur : rr_idx;
    xfer   = load & any_req & ~rst;
    grant  = '0;
    if (xfer) grant[winner] = 1'b1;
  end

  mux_8to1_8b u_mux (
    .sel (winner),
    .in0 (in0),
    .in1 (in1),
    .in2 (in2),
    .in3 (in3),
    .in4 (in4),
    .in5 (in5),
    .in6 (in6),
    .in7 (in7),
    .out (mux_dat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur       <= '0;
      cnt       <= '0;
      last      <= IDX_W'(NUM_CH - 1);
      sel       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      if (any_req) begin
        out_data  <= mux_dat;
        sel       <= winner;
        out_valid <= 1'b1;
        last      <= winner;
        if (cont) begin
          cnt <= cnt + 8'd1;
        end else begin
          // A fresh ownership starts even when the sole requester re-wins after its burst.
          cur   <= winner;
          cnt   <= 8'd1;
          state <= OWNED;
        end
      end else begin
        out_valid <= 1'b0;
        state     <= IDLE;
        cnt       <= '0;
      end
    end
  end

endmodule : arb_8to1_8b

// File: tb/tb_arb_8to1_8b.sv
module tb_arb_8to1_8b;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] req;
  logic [7:0] din [8];
  logic       out_ready;

  // Two instances: BURST_LEN=4 (index 0) and BURST_LEN=2 (index 1), same stimulus.
  logic [7:0] grant_o [2];
  logic [2:0] sel_o   [2];
  logic [7:0] data_o  [2];
  logic       valid_o [2];

  arb_8to1_8b #(.BURST_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .grant(grant_o[0]), .sel(sel_o[0]), .out_data(data_o[0]),
    .out_valid(valid_o[0]), .out_ready(out_ready)
  );

  arb_8to1_8b #(.BURST_LEN(2)) dut2 (
    .clk(clk), .rst(rst), .req(req),
    .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
    .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
    .grant(grant_o[1]), .sel(sel_o[1]), .out_data(data_o[1]),
    .out_valid(valid_o[1]), .out_ready(out_ready)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: owner/count/last bookkeeping per instance.
  int         bl      [2] = '{4, 2};
  bit         m_valid [2];
  logic [7:0] m_data  [2];
  int         m_sel   [2];
  bit         m_owned [2];
  int         m_owner [2];
  int         m_count [2];
  int         m_last  [2];
  logic [7:0] m_grant [2];
  int         m_win   [2];
  bit         m_cont  [2];

  function automatic int first_after(input logic [7:0] r, input int after);
    for (int k = 1; k <= 8; k++) begin
      if (r[(after + k) % 8]) return (after + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset(input int d);
    m_valid[d] = 0; m_data[d] = 8'h00; m_sel[d] = 0;
    m_owned[d] = 0; m_owner[d] = 0; m_count[d] = 0; m_last[d] = 7;
  endtask

  task automatic model_eval();
    for (int d = 0; d < 2; d++) begin
      bit can_load;
      can_load  = !m_valid[d] || out_ready;
      m_cont[d] = m_owned[d] && req[m_owner[d]] && (m_count[d] < bl[d]);
      m_win[d]  = m_cont[d] ? m_owner[d] : first_after(req, m_last[d]);
      m_grant[d] = 8'h00;
      if (!rst && can_load && req != 8'h00) m_grant[d] = 8'(1 << m_win[d]);
    end
  endtask

  task automatic model_clock();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        model_reset(d);
      end else if (!m_valid[d] || out_ready) begin
        if (req != 8'h00) begin
          m_data[d]  = din[m_win[d]];
          m_sel[d]   = m_win[d];
          m_valid[d] = 1;
          m_last[d]  = m_win[d];
          if (m_cont[d]) m_count[d]++;
          else begin
            m_owner[d] = m_win[d]; m_count[d] = 1; m_owned[d] = 1;
          end
        end else begin
          m_valid[d] = 0; m_owned[d] = 0; m_count[d] = 0;
        end
      end
    end
  endtask

  // Entered #1 after a rising edge with inputs already applied.
  task automatic cycle(input string tag);
    #2;
    model_eval();
    for (int d = 0; d < 2; d++)
      check($sformatf("%s.grant[bl%0d]", tag, bl[d]), 32'(grant_o[d]), 32'(m_grant[d]));
    @(posedge clk);
    model_clock();
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s.valid[bl%0d]", tag, bl[d]), 32'(valid_o[d]), 32'(m_valid[d]));
      check($sformatf("%s.sel[bl%0d]", tag, bl[d]), 32'(sel_o[d]), 32'(m_sel[d]));
      check($sformatf("%s.data[bl%0d]", tag, bl[d]), 32'(data_o[d]), 32'(m_data[d]));
    end
  endtask

  task automatic fresh_data();
    for (int i = 0; i < 8; i++) din[i] = 8'($urandom);
  endtask

  initial begin
    rst = 1'b1; req = 8'h00; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) din[i] = 8'(8'h10 * i + i);
    for (int d = 0; d < 2; d++) model_reset(d);
    @(posedge clk); #1;

    // Reset: grant forced low even with requests present.
    req = 8'hFF;
    cycle("reset0");
    cycle("reset1");

    // First grant after reset goes to the lowest requester.
    rst = 1'b0; req = 8'h24;
    cycle("first");
    fresh_data();
    cycle("first2");

    // Two requesters held: bursts alternate between ch0 and ch1.
    rst = 1'b1; req = 8'h00; cycle("rst_b");
    rst = 1'b0; req = 8'h03;
    for (int n = 0; n < 12; n++) begin fresh_data(); cycle("burst"); end

    // Backpressure while owned: state and output frozen, then resume.
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin fresh_data(); cycle("bp"); end
    out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin fresh_data(); cycle("bp_resume"); end

    // Sole requester at the top index re-wins with no bubbles.
    rst = 1'b1; req = 8'h00; cycle("rst_s");
    rst = 1'b0; req = 8'h80;
    for (int n = 0; n < 6; n++) begin fresh_data(); cycle("sole"); end

    // Early release from ch6 with wrap to ch0, then ch5.
    rst = 1'b1; req = 8'h00; cycle("rst_w");
    rst = 1'b0; req = 8'h40; fresh_data(); cycle("own6");
    req = 8'h21;
    for (int n = 0; n < 8; n++) begin fresh_data(); cycle("wrap"); end

    // Reset in the middle of a ch3 burst.
    req = 8'h08;
    for (int n = 0; n < 2; n++) begin fresh_data(); cycle("own3"); end
    rst = 1'b1; cycle("midrst");
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin fresh_data(); cycle("regain3"); end

    // Randomized traffic with backpressure and occasional reset.
    for (int n = 0; n < 600; n++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req       = (n % 3 == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      fresh_data();
      cycle("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_arb_8to1_8b
